// File: rtl/dac_spi_tx_pkg.sv
// ============================================================================
// Module      : dac_spi_tx_pkg
// Description : Shared DAC SPI frame constants, word field offsets and FSM
//               state encoding for dac_spi_tx and its upstream controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dac_spi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_HI = 3'd2,
        ST_SCK_LO = 3'd3,
        ST_GAP    = 3'd4
    } dac_state_t;

    localparam int unsigned FRAME_BITS     = 32;
    localparam int unsigned PAD_BITS       = 4;
    localparam int unsigned WORD_BITS      = FRAME_BITS - PAD_BITS;
    localparam int unsigned BIT_CNT_BITS   = 6;
    localparam int unsigned PHASE_CNT_BITS = 8;

    // Field offsets inside the 28-bit command word
    localparam int unsigned CMD_LSB   = 24;
    localparam int unsigned CMD_BITS  = 4;
    localparam int unsigned ADDR_LSB  = 20;
    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned DATA_LSB  = 8;
    localparam int unsigned DATA_BITS = 12;
    localparam int unsigned CTL_LSB   = 0;
    localparam int unsigned CTL_BITS  = 8;

    function automatic logic [WORD_BITS-1:0] dac_word(
        input logic [CMD_BITS-1:0]  cmd,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data,
        input logic [CTL_BITS-1:0]  ctl
    );
        return {cmd, addr, data, ctl};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_spi_tx_if.sv
// ============================================================================
// Module      : dac_spi_tx_if
// Description : Request/status and SPI pin bundle of dac_spi_tx; readback
//               signals exist only when DAC_SPI_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dac_spi_tx_if;
    import dac_spi_tx_pkg::*;

    logic                 go_DAC;
    logic [WORD_BITS-1:0] DAC_in;
    logic                 trans;
    logic                 DAC_CS;
    logic                 SPI_SCK;
    logic                 SPI_MOSI;
`ifdef DAC_SPI_READBACK_EN
    logic                  SPI_MISO;
    logic [FRAME_BITS-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output go_DAC, DAC_in, SPI_MISO,
        input  trans, DAC_CS, SPI_SCK, SPI_MOSI, rd_data, rd_valid
    );
    modport slave (
        input  go_DAC, DAC_in, SPI_MISO,
        output trans, DAC_CS, SPI_SCK, SPI_MOSI, rd_data, rd_valid
    );
`else
    modport master (
        output go_DAC, DAC_in,
        input  trans, DAC_CS, SPI_SCK, SPI_MOSI
    );
    modport slave (
        input  go_DAC, DAC_in,
        output trans, DAC_CS, SPI_SCK, SPI_MOSI
    );
`endif

endinterface

`default_nettype wire

// File: rtl/dac_spi_tx_spi_clk_div.sv
// ============================================================================
// Module      : spi_clk_div
// Description : Phase timer; strobes o_phase_end on the last of every
//               CLK_DIV cycles while enabled, held cleared otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    output logic      o_phase_end
);

    localparam logic [PHASE_CNT_BITS-1:0] c_LAST = PHASE_CNT_BITS'(CLK_DIV - 1);

    logic [PHASE_CNT_BITS-1:0] r_cnt;

    assign o_phase_end = i_en && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// Module      : dac_spi_tx
// Description : 32-bit SPI frame transmitter for a DAC (4 pad bits + 28-bit
//               word, MSB first). Optional MISO readback: DAC_SPI_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  wire logic   clk,
    input  wire logic   reset_Async,
    dac_spi_tx_if.slave bus
);

    localparam logic [BIT_CNT_BITS-1:0] c_LAST_BIT = BIT_CNT_BITS'(FRAME_BITS);

    dac_state_t              r_state;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [BIT_CNT_BITS-1:0] r_bit_cnt;
    logic                    r_trans;
    logic                    r_cs;
    logic                    r_sck;
    logic                    r_mosi;
    logic                    w_phase_end;
    logic                    w_busy;
    logic [FRAME_BITS-1:0]   w_frame_in;
`ifdef DAC_SPI_READBACK_EN
    logic [FRAME_BITS-1:0]   r_rd_data;
    logic                    r_rd_valid;
`endif

    assign w_busy     = (r_state != ST_IDLE);
    assign w_frame_in = {{PAD_BITS{1'b0}}, bus.DAC_in};

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk         (clk),
        .rst         (reset_Async),
        .i_en        (w_busy),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge clk or posedge reset_Async) begin
        if (reset_Async) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_trans   <= 1'b0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
`ifdef DAC_SPI_READBACK_EN
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
`endif
        end else begin
`ifdef DAC_SPI_READBACK_EN
            r_rd_valid <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.go_DAC) begin
                        r_shift   <= w_frame_in;
                        r_mosi    <= w_frame_in[FRAME_BITS-1];
                        r_bit_cnt <= '0;
                        r_trans   <= 1'b1;
                        r_cs      <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_phase_end) begin
                        r_sck   <= 1'b1;
                        r_state <= ST_SCK_HI;
`ifdef DAC_SPI_READBACK_EN
                        r_rd_data <= {r_rd_data[FRAME_BITS-2:0], bus.SPI_MISO};
`endif
                    end
                end
                ST_SCK_HI: begin
                    // Falling SCK: next bit goes out while SCK is low
                    if (w_phase_end) begin
                        r_sck     <= 1'b0;
                        r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        r_mosi    <= r_shift[FRAME_BITS-2];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_state   <= ST_SCK_LO;
                    end
                end
                ST_SCK_LO: begin
                    if (w_phase_end) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_cs    <= 1'b1;
                            r_mosi  <= 1'b0;
                            r_state <= ST_GAP;
`ifdef DAC_SPI_READBACK_EN
                            r_rd_valid <= 1'b1;
`endif
                        end else begin
                            r_sck   <= 1'b1;
                            r_state <= ST_SCK_HI;
`ifdef DAC_SPI_READBACK_EN
                            r_rd_data <= {r_rd_data[FRAME_BITS-2:0], bus.SPI_MISO};
`endif
                        end
                    end
                end
                ST_GAP: begin
                    if (w_phase_end) begin
                        r_trans   <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.trans    = r_trans;
    assign bus.DAC_CS   = r_cs;
    assign bus.SPI_SCK  = r_sck;
    assign bus.SPI_MOSI = r_mosi;
`ifdef DAC_SPI_READBACK_EN
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// ============================================================================
// Module      : tb_dac_spi_tx
// Description : Self-checking bench for dac_spi_tx at CLK_DIV 2, 1 and 255;
//               readback checks are active when DAC_SPI_READBACK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dac_spi_tx;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        go  [NDUT];
    logic [27:0] din [NDUT];
    logic [31:0] rb_pat;

    wire [31:0] mon_frame     [NDUT];
    wire [31:0] mon_width     [NDUT];
    wire [31:0] mon_rises     [NDUT];
    wire [31:0] mon_frames    [NDUT];
    wire [31:0] mon_cur_rises [NDUT];
    wire [31:0] mon_csgap     [NDUT];
    wire [31:0] mon_trgap     [NDUT];
    wire [31:0] mon_mosi_err  [NDUT];
    wire        mon_trans     [NDUT];
    wire        mon_cs        [NDUT];
    wire        mon_sck       [NDUT];
    wire        mon_mosi      [NDUT];
`ifdef DAC_SPI_READBACK_EN
    wire [31:0] mon_rd_data   [NDUT];
    wire [31:0] mon_rd_pulses [NDUT];
    wire        mon_rd_at_gap [NDUT];
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [27:0] word;
        logic [31:0] exp_frame;
    } vec_t;
    vec_t vecs [6];

    function automatic int div_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DIV = (gi == 0) ? 2 : (gi == 1) ? 1 : 255;

        dac_spi_tx_if bus ();

        assign bus.go_DAC = go[gi];
        assign bus.DAC_in = din[gi];

        dac_spi_tx #(
            .CLK_DIV (DIV)
        ) u_dut (
            .clk         (clk),
            .reset_Async (rst),
            .bus         (bus)
        );

        // Line-level monitor: rebuilds each frame from the pins
        logic [31:0] cur_frame = '0, last_frame = '0;
        int cur_rises = 0, last_rises = 0, cur_width = 0, last_width = 0;
        int frames = 0, cs_run = 0, last_cs_gap = 0, tr_run = 0, last_tr_gap = 0;
        int mosi_err = 0;
        logic p_sck = 1'b0, p_mosi = 1'b0, p_trans = 1'b0, p_cs = 1'b1;
`ifdef DAC_SPI_READBACK_EN
        int rd_cnt = 0, last_rd_pulses = 0;
        logic [31:0] rd_last = '0;
        logic rd_at_gap = 1'b0;
        assign bus.SPI_MISO = (cur_rises < 32) ? rb_pat[5'(31 - cur_rises)] : 1'b0;
        assign mon_rd_data[gi]   = rd_last;
        assign mon_rd_pulses[gi] = last_rd_pulses;
        assign mon_rd_at_gap[gi] = rd_at_gap;
`endif

        always @(negedge clk) begin
            p_sck   <= bus.SPI_SCK;
            p_mosi  <= bus.SPI_MOSI;
            p_trans <= bus.trans;
            p_cs    <= bus.DAC_CS;
            if (rst) begin
                cur_frame <= '0;
                cur_rises <= 0;
                cur_width <= 0;
                cs_run    <= 0;
                tr_run    <= 0;
`ifdef DAC_SPI_READBACK_EN
                rd_cnt    <= 0;
`endif
            end else begin
                if (!bus.trans && p_trans) begin
                    last_frame <= cur_frame;
                    last_rises <= cur_rises;
                    last_width <= cur_width;
                    frames     <= frames + 1;
                    cur_frame  <= '0;
                    cur_rises  <= 0;
                    cur_width  <= 0;
`ifdef DAC_SPI_READBACK_EN
                    last_rd_pulses <= rd_cnt;
                    rd_cnt         <= 0;
`endif
                end else begin
                    if (bus.trans) cur_width <= cur_width + 1;
                    if (bus.SPI_SCK && !p_sck) begin
                        cur_frame <= {cur_frame[30:0], bus.SPI_MOSI};
                        cur_rises <= cur_rises + 1;
                    end
`ifdef DAC_SPI_READBACK_EN
                    if (bus.rd_valid) begin
                        rd_cnt    <= rd_cnt + 1;
                        rd_last   <= bus.rd_data;
                        rd_at_gap <= bus.DAC_CS && !p_cs;
                    end
`endif
                end
                if (bus.SPI_SCK && p_sck && (bus.SPI_MOSI != p_mosi)) mosi_err <= mosi_err + 1;
                if (bus.DAC_CS) begin
                    cs_run <= cs_run + 1;
                end else begin
                    cs_run <= 0;
                    if (p_cs) last_cs_gap <= cs_run;
                end
                if (!bus.trans) begin
                    tr_run <= tr_run + 1;
                end else begin
                    tr_run <= 0;
                    if (!p_trans) last_tr_gap <= tr_run;
                end
            end
        end

        assign mon_frame[gi]     = last_frame;
        assign mon_width[gi]     = last_width;
        assign mon_rises[gi]     = last_rises;
        assign mon_frames[gi]    = frames;
        assign mon_cur_rises[gi] = cur_rises;
        assign mon_csgap[gi]     = last_cs_gap;
        assign mon_trgap[gi]     = last_tr_gap;
        assign mon_mosi_err[gi]  = mosi_err;
        assign mon_trans[gi]     = bus.trans;
        assign mon_cs[gi]        = bus.DAC_CS;
        assign mon_sck[gi]       = bus.SPI_SCK;
        assign mon_mosi[gi]      = bus.SPI_MOSI;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send(input int k, input logic [27:0] w);
        din[k] = w;
        go[k]  = 1'b1;
        @(posedge clk);
        #1;
        go[k]  = 1'b0;
    endtask

    task automatic wait_frame(input int k, input int prev);
        int budget;
        budget = 66 * div_of(k) + 64;
        while (mon_frames[k] == 32'(prev) && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (mon_frames[k] == 32'(prev)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout dut%0d: got no end of frame, required one within %0d cycles",
                     k, 66 * div_of(k) + 64);
        end
    endtask

    task automatic check_frame(input int k, input logic [31:0] exp, input string tag);
        check({tag, "_frame"}, mon_frame[k], exp);
        check({tag, "_trans_width"}, mon_width[k], 32'(66 * div_of(k)));
        check({tag, "_sck_rises"}, mon_rises[k], 32'd32);
    endtask

    initial begin
        int          prev;
        int          prev2;
        int          cnt;
        logic [27:0] w;
        logic [31:0] exp_q [$];

        vecs[0] = '{28'h30A5C00, 32'h030A_5C00};
        vecs[1] = '{28'h8000001, 32'h0800_0001};
        vecs[2] = '{28'hFFFFFFF, 32'h0FFF_FFFF};
        vecs[3] = '{28'h0000000, 32'h0000_0000};
        vecs[4] = '{28'h5555555, 32'h0555_5555};
        vecs[5] = '{28'hAAAAAAA, 32'h0AAA_AAAA};

        for (int k = 0; k < NDUT; k++) begin
            go[k]  = 1'b0;
            din[k] = '0;
        end
        rb_pat = 32'hDEAD_BEEF;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_trans", {31'd0, mon_trans[0]}, 32'd0);
        check("reset_cs",    {31'd0, mon_cs[0]},    32'd1);
        check("reset_sck",   {31'd0, mon_sck[0]},   32'd0);
        check("reset_mosi",  {31'd0, mon_mosi[0]},  32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table vectors on the CLK_DIV=2 instance
        for (int v = 0; v < 6; v++) begin
            prev = mon_frames[0];
            send(0, vecs[v].word);
            wait_frame(0, prev);
            check_frame(0, vecs[v].exp_frame, $sformatf("vec%0d", v));
`ifdef DAC_SPI_READBACK_EN
            check($sformatf("vec%0d_rd_data", v),   mon_rd_data[0],   rb_pat);
            check($sformatf("vec%0d_rd_pulses", v), mon_rd_pulses[0], 32'd1);
            check($sformatf("vec%0d_rd_at_gap", v), {31'd0, mon_rd_at_gap[0]}, 32'd1);
`endif
            repeat (3) @(posedge clk);
            #1;
        end

        // go_DAC during a frame is dropped, not queued
        prev = mon_frames[0];
        send(0, 28'hC3C3C3C);
        repeat (8) @(posedge clk);
        #1;
        din[0] = 28'h1111111;
        go[0]  = 1'b1;
        @(posedge clk);
        #1;
        go[0]  = 1'b0;
        repeat (89) @(posedge clk);
        #1;
        din[0] = 28'h2222222;
        go[0]  = 1'b1;
        @(posedge clk);
        #1;
        go[0]  = 1'b0;
        wait_frame(0, prev);
        check_frame(0, 32'h0C3C_3C3C, "ignore_go");
        repeat (200) @(negedge clk);
        #1;
        check("ignore_go_frame_count", mon_frames[0], 32'(prev + 1));
        check("ignore_go_idle_trans", {31'd0, mon_trans[0]}, 32'd0);

        // Asynchronous reset after the 17th SCK rise
        prev = mon_frames[0];
        send(0, 28'h5A5A5A5);
        cnt = 0;
        while (mon_cur_rises[0] != 32'd17 && cnt < 200) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rst17_timeout: got %0d SCK rises, required 17", mon_cur_rises[0]);
        end
        rst = 1'b1;
        #1;
        check("rst17_trans", {31'd0, mon_trans[0]}, 32'd0);
        check("rst17_cs",    {31'd0, mon_cs[0]},    32'd1);
        check("rst17_sck",   {31'd0, mon_sck[0]},   32'd0);
        check("rst17_mosi",  {31'd0, mon_mosi[0]},  32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst17_no_partial_frame", mon_frames[0], 32'(prev));
        prev = mon_frames[0];
        send(0, 28'h7654321);
        wait_frame(0, prev);
        check_frame(0, 32'h0765_4321, "after_rst");

        // Back-to-back frames: second request in the first IDLE cycle
        repeat (2) @(posedge clk);
        #1;
        prev = mon_frames[0];
        send(0, 28'h1234567);
        wait_frame(0, prev);
        check_frame(0, 32'h0123_4567, "b2b_first");
        prev   = mon_frames[0];
        din[0] = 28'h8000001;
        go[0]  = 1'b1;
        @(posedge clk);
        #1;
        go[0]  = 1'b0;
        wait_frame(0, prev);
        check_frame(0, 32'h0800_0001, "b2b_second");
        check("b2b_cs_high_cycles", mon_csgap[0], 32'd3);
        check("b2b_trans_low_cycles", mon_trgap[0], 32'd1);

        // CLK_DIV extremes run side by side
        prev   = mon_frames[1];
        prev2  = mon_frames[2];
        din[1] = 28'h30A5C00;
        din[2] = 28'h30A5C00;
        go[1]  = 1'b1;
        go[2]  = 1'b1;
        @(posedge clk);
        #1;
        go[1]  = 1'b0;
        go[2]  = 1'b0;
        din[1] = 28'hFFFFFFF;
        din[2] = 28'hFFFFFFF;
        wait_frame(1, prev);
        check_frame(1, 32'h030A_5C00, "div1");
        wait_frame(2, prev2);
        check_frame(2, 32'h030A_5C00, "div255");

        // Random words with noise on go_DAC / DAC_in during the frame
        for (int n = 0; n < 20; n++) begin
            w = 28'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            exp_q.push_back({4'b0000, w});
            prev = mon_frames[0];
            send(0, w);
            din[0] = 28'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 120)) @(posedge clk);
                #1;
                din[0] = 28'($urandom);
                go[0]  = 1'b1;
                @(posedge clk);
                #1;
                go[0]  = 1'b0;
            end
            wait_frame(0, prev);
            check_frame(0, exp_q.pop_front(), $sformatf("rand%0d", n));
        end

        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("mosi_stable_sck_high_dut%0d", k), mon_mosi_err[k], 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
